// File: rtl/weights_ctrl_pkg.sv
// Shared types for the weights BRAM controller: FSM states and the
// {valid,last} sideband entry carried alongside the BRAM read latency.
package weights_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FILL  = 3'd2,
    READ  = 3'd3,
    DRAIN = 3'd4
  } state_e;

  typedef struct packed {
    logic valid;
    logic last;
  } pipe_entry_t;

endpackage

// File: rtl/weights_bram_ctrl_valid_pipe.sv
// Enable-gated {valid,last} shift register that tracks words in flight
// through the BRAM read latency.
module valid_pipe
  import weights_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  pipe_entry_t din,
  output pipe_entry_t dout,
  output logic        busy
);

  pipe_entry_t stages [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        stages[i] <= '0;
      end
    end else if (en) begin
      stages[0] <= din;
      for (int i = 1; i < int'(DEPTH); i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign dout = stages[DEPTH-1];

  // Valid entries still upstream of the output stage.
  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < int'(DEPTH) - 1; i++) begin
      busy = busy | stages[i].valid;
    end
  end

endmodule

// File: rtl/weights_bram_ctrl.sv
// Weights path controller in front of cyclic_bram: fills one block from the
// input stream, then issues cyclic reads for a configured number of passes.
module weights_bram_ctrl
  import weights_ctrl_pkg::*;
#(
  parameter  int unsigned W_DATA_WIDTH = 8,
  parameter  int unsigned R_DEPTH      = 8,
  parameter  int unsigned W_DEPTH      = 8,
  parameter  int unsigned LATENCY      = 3,
  parameter  int unsigned REPS_WIDTH   = 8,
  localparam int unsigned R_ADDR_WIDTH = $clog2(R_DEPTH),
  localparam int unsigned W_ADDR_WIDTH = $clog2(W_DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [R_ADDR_WIDTH-1:0] cfg_r_addr_min,
  input  logic [R_ADDR_WIDTH-1:0] cfg_r_addr_max,
  input  logic [REPS_WIDTH-1:0]   cfg_reps,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [W_DATA_WIDTH-1:0] s_data,
  input  logic                    s_last,
  input  logic                    m_ready,
  output logic                    m_valid,
  output logic                    m_last,
  output logic                    bram_clken,
  output logic                    bram_resetn_local,
  output logic                    bram_w_en,
  output logic                    bram_r_en,
  output logic [W_DATA_WIDTH-1:0] bram_s_data,
  output logic [R_ADDR_WIDTH-1:0] bram_r_addr_min,
  output logic [R_ADDR_WIDTH-1:0] bram_r_addr_max,
  output logic                    err_overflow
);

  // One extra bit so the beat counter can hold W_DEPTH itself.
  localparam int unsigned W_CNT_WIDTH = W_ADDR_WIDTH + 1;

  state_e                  state;
  state_e                  state_nxt;
  logic [R_ADDR_WIDTH-1:0] r_cnt;
  logic [REPS_WIDTH-1:0]   reps_q;
  logic [REPS_WIDTH-1:0]   pass_q;
  logic [W_CNT_WIDTH-1:0]  w_cnt;
  logic                    cfg_fire;
  logic                    s_fire;
  logic                    rd_issue;
  logic                    rd_last;
  logic                    last_accept;
  logic                    pipe_busy;
  pipe_entry_t             pipe_in;
  pipe_entry_t             pipe_out;

  assign cfg_fire    = cfg_valid && cfg_ready;
  assign s_fire      = s_valid && s_ready;
  assign rd_issue    = bram_r_en;
  assign rd_last     = (r_cnt == bram_r_addr_max) &&
                       (pass_q == reps_q - REPS_WIDTH'(1));
  assign last_accept = m_valid && m_ready && m_last;

  // A stalled output word freezes the BRAM, read counters and sideband pipe.
  assign bram_clken  = !m_valid || m_ready;
  assign bram_s_data = s_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cfg_fire) state_nxt = CLEAR;
      CLEAR:   state_nxt = FILL;
      FILL:    if (s_fire && s_last) state_nxt = READ;
      READ:    if (rd_issue && rd_last) state_nxt = DRAIN;
      DRAIN:   if (last_accept && !pipe_busy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cfg_ready         = 1'b0;
    s_ready           = 1'b0;
    bram_w_en         = 1'b0;
    bram_r_en         = 1'b0;
    bram_resetn_local = 1'b1;
    case (state)
      IDLE:    cfg_ready = 1'b1;
      CLEAR:   bram_resetn_local = 1'b0;
      FILL: begin
        s_ready   = 1'b1;
        bram_w_en = s_valid;
      end
      READ:    bram_r_en = bram_clken;
      default: ;
    endcase
  end

  // Configuration capture; reps of zero runs a single pass.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bram_r_addr_min <= '0;
      bram_r_addr_max <= '0;
      reps_q          <= '0;
    end else if (cfg_fire) begin
      bram_r_addr_min <= cfg_r_addr_min;
      bram_r_addr_max <= cfg_r_addr_max;
      reps_q          <= (cfg_reps == '0) ? REPS_WIDTH'(1) : cfg_reps;
    end
  end

  // Write beat count; beats past W_DEPTH still write but raise the sticky flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_cnt        <= '0;
      err_overflow <= 1'b0;
    end else if (cfg_fire) begin
      w_cnt        <= '0;
      err_overflow <= 1'b0;
    end else if (s_fire) begin
      if (w_cnt == W_CNT_WIDTH'(W_DEPTH)) begin
        err_overflow <= 1'b1;
      end else begin
        w_cnt <= w_cnt + W_CNT_WIDTH'(1);
      end
    end
  end

  // Mirror of the BRAM read address and the completed-pass count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      pass_q <= '0;
    end else if (cfg_fire) begin
      r_cnt  <= cfg_r_addr_min;
      pass_q <= '0;
    end else if (rd_issue) begin
      if (r_cnt == bram_r_addr_max) begin
        r_cnt  <= bram_r_addr_min;
        pass_q <= pass_q + REPS_WIDTH'(1);
      end else begin
        r_cnt <= r_cnt + R_ADDR_WIDTH'(1);
      end
    end
  end

  assign pipe_in = '{valid: rd_issue, last: rd_issue && rd_last};

  valid_pipe #(
    .DEPTH (LATENCY)
  ) u_valid_pipe (
    .clk  (clk),
    .rst  (rst),
    .en   (bram_clken),
    .din  (pipe_in),
    .dout (pipe_out),
    .busy (pipe_busy)
  );

  assign m_valid = pipe_out.valid;
  assign m_last  = pipe_out.last;

endmodule

// File: tb/tb_weights_bram_ctrl.sv
// Directed and randomized checks of weights_bram_ctrl against a simple
// cyclic BRAM environment model and an address-order reference.
module tb_weights_bram_ctrl;

  localparam int unsigned DW  = 8;
  localparam int unsigned RD  = 8;
  localparam int unsigned WD  = 8;
  localparam int unsigned LAT = 3;
  localparam int unsigned RW  = 8;
  localparam int unsigned AW  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [AW-1:0] cfg_r_addr_min;
  logic [AW-1:0] cfg_r_addr_max;
  logic [RW-1:0] cfg_reps;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          s_last;
  logic          m_ready;
  logic          m_valid;
  logic          m_last;
  logic          bram_clken;
  logic          bram_resetn_local;
  logic          bram_w_en;
  logic          bram_r_en;
  logic [DW-1:0] bram_s_data;
  logic [AW-1:0] bram_r_addr_min;
  logic [AW-1:0] bram_r_addr_max;
  logic          err_overflow;
  logic [DW-1:0] m_data;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  weights_bram_ctrl #(
    .W_DATA_WIDTH (DW),
    .R_DEPTH      (RD),
    .W_DEPTH      (WD),
    .LATENCY      (LAT),
    .REPS_WIDTH   (RW)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .cfg_valid         (cfg_valid),
    .cfg_ready         (cfg_ready),
    .cfg_r_addr_min    (cfg_r_addr_min),
    .cfg_r_addr_max    (cfg_r_addr_max),
    .cfg_reps          (cfg_reps),
    .s_valid           (s_valid),
    .s_ready           (s_ready),
    .s_data            (s_data),
    .s_last            (s_last),
    .m_ready           (m_ready),
    .m_valid           (m_valid),
    .m_last            (m_last),
    .bram_clken        (bram_clken),
    .bram_resetn_local (bram_resetn_local),
    .bram_w_en         (bram_w_en),
    .bram_r_en         (bram_r_en),
    .bram_s_data       (bram_s_data),
    .bram_r_addr_min   (bram_r_addr_min),
    .bram_r_addr_max   (bram_r_addr_max),
    .err_overflow      (err_overflow)
  );

  // Cyclic BRAM stand-in: wrapping write address, cyclic read address, LAT-deep read data.
  logic [DW-1:0] bmem [WD];
  logic [AW-1:0] bw_addr;
  logic [AW-1:0] br_addr;
  logic [DW-1:0] brd [LAT];

  always @(posedge clk) begin
    if (!bram_resetn_local) begin
      bw_addr <= '0;
      br_addr <= bram_r_addr_min;
    end else if (bram_clken) begin
      if (bram_w_en) begin
        bmem[bw_addr] <= bram_s_data;
        bw_addr       <= bw_addr + AW'(1);
      end
      if (bram_r_en) begin
        br_addr <= (br_addr == bram_r_addr_max) ? bram_r_addr_min : br_addr + AW'(1);
      end
    end
    if (bram_clken) begin
      if (bram_r_en) brd[0] <= bmem[br_addr];
      for (int i = 1; i < int'(LAT); i++) brd[i] <= brd[i-1];
    end
  end

  assign m_data = brd[LAT-1];

  // Output monitor, sampled on the falling edge.
  logic [DW-1:0] got_q [$];
  int cyc = 0;
  int ren_cnt, last_cnt, last_idx, clk_err, first_ren, first_mv;

  always @(negedge clk) begin
    cyc++;
    if (bram_clken !== (!m_valid || m_ready)) clk_err++;
    if (bram_r_en && !bram_clken) clk_err++;
    if (bram_r_en) begin
      ren_cnt++;
      if (first_ren < 0) first_ren = cyc;
    end
    if (m_valid && first_mv < 0) first_mv = cyc;
    if (m_valid && m_ready) begin
      got_q.push_back(m_data);
      if (m_last) begin
        last_cnt++;
        last_idx = got_q.size();
      end
    end
  end

  logic [DW-1:0] ref_mem [WD];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    got_q.delete();
    ren_cnt   = 0;
    last_cnt  = 0;
    last_idx  = 0;
    clk_err   = 0;
    first_ren = -1;
    first_mv  = -1;
  endtask

  task automatic do_cfg(input int mn, input int mx, input int rp);
    int b = 0;
    while (!cfg_ready && b < 100) begin
      step();
      b++;
    end
    chk("cfg_ready_wait", 32'(cfg_ready), 32'd1);
    cfg_valid      = 1'b1;
    cfg_r_addr_min = AW'(mn);
    cfg_r_addr_max = AW'(mx);
    cfg_reps       = RW'(rp);
    step();
    cfg_valid = 1'b0;
    chk("clear_pulse", 32'(bram_resetn_local), 32'd0);
    chk("ovf_cleared", 32'(err_overflow), 32'd0);
    chk("cfg_ready_busy", 32'(cfg_ready), 32'd0);
    step();
    chk("clear_one_cycle", 32'(bram_resetn_local), 32'd1);
    chk("fill_s_ready", 32'(s_ready), 32'd1);
  endtask

  task automatic do_fill(input int nb);
    logic [DW-1:0] d;
    for (int i = 0; i < nb; i++) begin
      d       = DW'($urandom);
      s_valid = 1'b1;
      s_data  = d;
      s_last  = (i == nb - 1);
      ref_mem[i % int'(WD)] = d;
      step();
      chk("ovf_flag", 32'(err_overflow), (i >= int'(WD)) ? 32'd1 : 32'd0);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk("s_ready_after_fill", 32'(s_ready), 32'd0);
  endtask

  task automatic do_drain(input bit bp);
    int b    = 0;
    bit done = 1'b0;
    while (!done && b < 3000) begin
      m_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
      b++;
      done = cfg_ready;
    end
    m_ready = 1'b1;
    chk("drain_timeout", 32'(done), 32'd1);
  endtask

  task automatic check_block(input int mn, input int mx, input int rp, input bit exp_ovf);
    logic [DW-1:0] exp_q [$];
    int passes = (rp == 0) ? 1 : rp;
    int mism   = 0;
    for (int p = 0; p < passes; p++)
      for (int a = mn; a <= mx; a++) exp_q.push_back(ref_mem[a]);
    foreach (exp_q[i]) begin
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) mism++;
    end
    chk("beat_count", 32'(got_q.size()), 32'(exp_q.size()));
    chk("data_order_mismatches", 32'(mism), 32'd0);
    chk("last_count", 32'(last_cnt), 32'd1);
    chk("last_position", 32'(last_idx), 32'(exp_q.size()));
    chk("read_count", 32'(ren_cnt), 32'(exp_q.size()));
    chk("first_latency", 32'(first_mv - first_ren), 32'(LAT));
    chk("clken_rule_errors", 32'(clk_err), 32'd0);
    chk("ovf_sticky", 32'(err_overflow), 32'(exp_ovf));
    chk("idle_m_valid", 32'(m_valid), 32'd0);
  endtask

  task automatic run_block(input int mn, input int mx, input int rp, input int nb, input bit bp);
    clear_mon();
    do_cfg(mn, mx, rp);
    do_fill(nb);
    do_drain(bp);
    check_block(mn, mx, rp, nb > int'(WD));
  endtask

  initial begin
    int b, mn, mx, rp;
    rst            = 1'b1;
    cfg_valid      = 1'b0;
    cfg_r_addr_min = '0;
    cfg_r_addr_max = '0;
    cfg_reps       = '0;
    s_valid        = 1'b0;
    s_data         = '0;
    s_last         = 1'b0;
    m_ready        = 1'b1;
    clear_mon();
    repeat (3) step();

    chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_last", 32'(m_last), 32'd0);
    chk("rst_w_en", 32'(bram_w_en), 32'd0);
    chk("rst_r_en", 32'(bram_r_en), 32'd0);
    chk("rst_resetn_local", 32'(bram_resetn_local), 32'd1);
    chk("rst_clken", 32'(bram_clken), 32'd1);
    chk("rst_err_overflow", 32'(err_overflow), 32'd0);
    chk("rst_addr_min", 32'(bram_r_addr_min), 32'd0);
    chk("rst_addr_max", 32'(bram_r_addr_max), 32'd0);
    rst = 1'b0;
    step();

    run_block(0, 7, 2, 8, 1'b0);
    run_block(2, 5, 3, 8, 1'b0);
    run_block(0, 7, 2, 8, 1'b1);
    run_block(0, 7, 1, 9, 1'b0);
    run_block(3, 3, 0, 8, 1'b0);

    // Reset in the middle of the read phase.
    clear_mon();
    do_cfg(0, 7, 2);
    do_fill(8);
    b = 0;
    while (ren_cnt < 5 && b < 100) begin
      step();
      b++;
    end
    chk("reads_before_reset", 32'(ren_cnt), 32'd5);
    chk("m_valid_before_reset", 32'(m_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_m_valid", 32'(m_valid), 32'd0);
    chk("midrst_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("midrst_r_en", 32'(bram_r_en), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    run_block(1, 6, 2, 8, 1'b1);

    for (int k = 0; k < 3; k++) begin
      mn = int'($urandom_range(0, 7));
      mx = int'($urandom_range(mn, 7));
      rp = int'($urandom_range(0, 4));
      run_block(mn, mx, rp, 8, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/weights_bram_ctrl.md
Name: weights_bram_ctrl

Overview:
- Controller placed directly upstream of cyclic_bram in the weights path.
- Accepts one weight block per configuration on an input stream and drives the BRAM write side until s_last.
- Then drives cyclic reads over [r_addr_min, r_addr_max] for a configured number of passes.
- Produces a valid/last sideband aligned to the BRAM's registered read data, and handles downstream backpressure by gating the BRAM clock enable.

Parameters:
- W_DATA_WIDTH, 8, input stream / BRAM write width.
- R_DEPTH, 8, BRAM read depth; R_ADDR_WIDTH = $clog2(R_DEPTH).
- W_DEPTH, 8, BRAM write depth; W_ADDR_WIDTH = $clog2(W_DEPTH).
- LATENCY, 3, BRAM read latency in clken-qualified cycles.
- REPS_WIDTH, 8, width of the pass counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- cfg_valid  in  1  configuration valid.
- cfg_ready  out  1  asserted only in IDLE.
- cfg_r_addr_min  in  R_ADDR_WIDTH  first read address.
- cfg_r_addr_max  in  R_ADDR_WIDTH  last read address before wrap.
- cfg_reps  in  REPS_WIDTH  number of read passes; 0 is treated as 1.
- s_valid  in  1  input weight beat valid.
- s_ready  out  1  input weight beat ready.
- s_data  in  W_DATA_WIDTH  input weight data.
- s_last  in  1  final beat of the block.
- m_ready  in  1  downstream accepts aligned BRAM data.
- m_valid  out  1  BRAM m_data valid this cycle.
- m_last  out  1  final read word of the block.
- bram_clken  out  1  to BRAM clken.
- bram_resetn_local  out  1  to BRAM resetn_local (active-low local clear).
- bram_w_en  out  1  to BRAM w_en.
- bram_r_en  out  1  to BRAM r_en.
- bram_s_data  out  W_DATA_WIDTH  to BRAM s_data.
- bram_r_addr_min  out  R_ADDR_WIDTH  registered copy of cfg_r_addr_min.
- bram_r_addr_max  out  R_ADDR_WIDTH  registered copy of cfg_r_addr_max.
- err_overflow  out  1  sticky flag: more than W_DEPTH beats written.

Behaviour:
- Reset: state=IDLE, all counters 0. Outputs: cfg_ready=1, s_ready=0, m_valid=0, m_last=0, bram_w_en=0, bram_r_en=0, bram_resetn_local=1, bram_clken=1, err_overflow=0, addr registers 0.
- Reset mid-operation: aborts immediately with no drain. The valid/last pipe is cleared, and the next configuration begins with CLEAR.
- bram_clken = !m_valid || m_ready. A stall freezes the BRAM, the read counters and the valid/last pipe together.
- bram_s_data = s_data (combinational pass-through).
- IDLE: on cfg_valid&&cfg_ready, latch min, max and reps (reps = max(cfg_reps,1)); clear err_overflow; go to CLEAR.
- CLEAR: exactly one cycle with bram_resetn_local=0, zeroing the BRAM's internal addresses; then go to FILL.
- FILL:
  - s_ready=1 and bram_w_en = s_valid.
  - A write beat counter increments per accepted beat.
  - An accepted beat with a count already equal to W_DEPTH sets err_overflow; the write still occurs and the BRAM address wraps.
  - On an accepted beat with s_last=1, go to READ on the next cycle.
  - s_ready=0 in every other state.
- READ:
  - bram_r_en = bram_clken, with bram_w_en=0.
  - A mirror counter r_cnt starts at min. Each issued read advances it: min..max, then wraps to min.
  - Each wrap increments the pass count.
  - The read issued with r_cnt==max and pass==reps-1 is tagged last; the FSM then goes to DRAIN.
  - One read is issued per enabled cycle.
- Degenerate range: min==max gives one word per pass; min>max is undefined and need not be checked.
- Pipe: a LATENCY-deep shift register of {valid,last}, advanced only when bram_clken=1. Its input is {read issued, last tag}; its output drives m_valid/m_last. The first m_valid therefore appears LATENCY enabled cycles after the first read.
- DRAIN: no reads. Return to IDLE once the pipe holds no valid entry and the final m_valid has been accepted (m_valid&&m_ready with m_last). cfg_ready is 0 until then.
- Throughput: one word per cycle in READ when m_ready is held high.

Decomposition:
- Package weights_ctrl_pkg: state enum (IDLE, CLEAR, FILL, READ, DRAIN) and a pipe-entry struct {valid,last}.
- Sub-module: valid_pipe (parameterised depth, enable-gated {valid,last} shift register), reused for the BRAM latency alignment.

Test Plan:
- Basic block: cfg min=0, max=7, reps=2; 8 beats with s_last on beat 8 -> exactly 16 m_valid beats, read address order 0..7,0..7, m_last only on beat 16; first m_valid 3 cycles after the first bram_r_en.
- Sub-range: min=2, max=5, reps=3 -> read order 2,3,4,5 repeated 3 times, 12 m_valid beats.
- Backpressure: m_ready toggled 1,0,0,1 randomly -> bram_clken=0 on every stalled valid cycle, no m_valid beat lost or duplicated, count still 16.
- Overflow: 9 beats with W_DEPTH=8 -> err_overflow=1 after beat 9 and stays 1 until the next cfg handshake.
- reps=0 and min==max=3 -> exactly one m_valid with m_last=1.
- rst asserted in READ after 5 reads -> next cycle IDLE, m_valid=0, cfg_ready=1; a new cfg produces a 1-cycle bram_resetn_local=0 pulse.
